// File: rtl/clk_div_sel.sv
// ----------------------------------------------------------------------------
// clk_div_sel
//
// Glitch-free selector for the divided clocks from the 3-bit mclk divider.
// The chosen divider bit (or constant 0 when off) is re-registered onto
// clk_out. A one-mclk enable strobe is registered alongside it. A change of
// selection is applied only at the divider wrap point (count 7), so the new
// clock always starts at the beginning of a full low phase.
//
// Handshake/strobe semantics: cfg_sel is a level request that may change on
// any cycle. sel_busy is high while a request differing from active_sel is
// pending. switch_done is a single-cycle pulse in the cycle active_sel first
// shows the new value. clk_en is a single-cycle pulse coincident with every
// 0->1 transition of clk_out.
//
// Ports:
//   mclk        in   master clock (also clocks the upstream divider)
//   reset_n     in   asynchronous active-low reset
//   clk_div_2   in   divider bit0 (div-by-2)
//   clk_div_4   in   divider bit1 (div-by-4)
//   clk_div_8   in   divider bit2 (div-by-8)
//   cfg_sel     in   requested selection: 0=off 1=div2 2=div4 3=div8
//   clk_out     out  selected divided clock, registered
//   clk_en      out  1-mclk strobe on each clk_out rising transition
//   active_sel  out  selection currently driving clk_out
//   sel_busy    out  high while a selection change is pending
//   switch_done out  1-mclk strobe when active_sel is updated
//   state_dbg   out  current FSM state (0=IDLE, 1=WAIT), for observation
// ----------------------------------------------------------------------------
module clk_div_sel #(
    parameter logic [1:0] RESET_SEL = 2'd0
) (
    input  logic       mclk,
    input  logic       reset_n,
    input  logic       clk_div_2,
    input  logic       clk_div_4,
    input  logic       clk_div_8,
    input  logic [1:0] cfg_sel,
    output logic       clk_out,
    output logic       clk_en,
    output logic [1:0] active_sel,
    output logic       sel_busy,
    output logic       switch_done,
    output logic       state_dbg
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] pending_sel;
    logic [1:0] pending_nxt;
    logic [1:0] active_nxt;
    logic       done_nxt;
    logic       sel_val;
    logic       align;

    // Clock value chosen by the selection currently in force.
    always_comb begin
        sel_val = 1'b0;
        case (active_sel)
            2'd0:    sel_val = 1'b0;
            2'd1:    sel_val = clk_div_2;
            2'd2:    sel_val = clk_div_4;
            2'd3:    sel_val = clk_div_8;
            default: sel_val = 1'b0;
        endcase
    end

    // Divider count 7: on the next edge every divider bit falls together,
    // so switching here lets the old clock finish its high phase and the
    // new clock begin with a full low phase.
    assign align = clk_div_8 & clk_div_4 & clk_div_2;

    // Output clock and its rising-edge strobe.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
        end else begin
            clk_out <= sel_val;
            clk_en  <= sel_val & ~clk_out;
        end
    end

    // Selection FSM: state and selection registers.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pending_sel <= RESET_SEL;
            active_sel  <= RESET_SEL;
            switch_done <= 1'b0;
            sel_busy    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pending_sel <= pending_nxt;
            active_sel  <= active_nxt;
            switch_done <= done_nxt;
            sel_busy    <= (state_nxt == S_WAIT);
        end
    end

    // Selection FSM: next-state logic. A request seen in IDLE never switches
    // in the same cycle, even at align; it always waits for the next wrap.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending_sel;
        active_nxt  = active_sel;
        done_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_sel != active_sel) begin
                    pending_nxt = cfg_sel;
                    state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                // The latest request always wins.
                pending_nxt = cfg_sel;
                if (cfg_sel == active_sel) begin
                    state_nxt = S_IDLE;
                end else if (align) begin
                    active_nxt = cfg_sel;
                    done_nxt   = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_clk_div_sel.sv
// ----------------------------------------------------------------------------
// tb_clk_div_sel
//
// Bench for clk_div_sel. A free-running 3-bit counter stands in for the
// upstream divider. A behavioural model tracks the expected selection from
// the switching rules. It derives the expected clock from the counter value
// arithmetically: a div-by-2^k clock is bit k-1 of the count.
// ----------------------------------------------------------------------------
module tb_clk_div_sel;

    logic       mclk = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] cfg_sel = 2'd0;
    logic       clk_out;
    logic       clk_en;
    logic [1:0] active_sel;
    logic       sel_busy;
    logic       switch_done;
    logic       state_dbg;

    // Stand-in for the upstream divider; hold forces it to 0.
    logic [2:0] div_cnt = 3'd0;
    logic       hold = 1'b0;
    logic       clk_div_2;
    logic       clk_div_4;
    logic       clk_div_8;

    int total = 0;
    int bad = 0;

    clk_div_sel #(.RESET_SEL(2'd0)) dut (
        .mclk        (mclk),
        .reset_n     (reset_n),
        .clk_div_2   (clk_div_2),
        .clk_div_4   (clk_div_4),
        .clk_div_8   (clk_div_8),
        .cfg_sel     (cfg_sel),
        .clk_out     (clk_out),
        .clk_en      (clk_en),
        .active_sel  (active_sel),
        .sel_busy    (sel_busy),
        .switch_done (switch_done),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset / divider ----------------
    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        if (hold) div_cnt <= 3'd0;
        else      div_cnt <= div_cnt + 3'd1;
    end

    assign clk_div_2 = div_cnt[0];
    assign clk_div_4 = div_cnt[1];
    assign clk_div_8 = div_cnt[2];

    // ---------------- reference model ----------------
    logic [1:0] m_active = 2'd0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_out = 1'b0;
    logic       m_en = 1'b0;

    // Divided clock level for a selection at a given divider count.
    function automatic logic div_level(input logic [1:0] sel, input int cnt);
        int s;
        int pw;
        s = int'(sel);
        if (s == 0) return 1'b0;
        pw = 1 << (s - 1);
        return ((cnt / pw) % 2) == 1;
    endfunction

    // Evaluated on each edge with the pre-edge counter and request.
    always @(posedge mclk or negedge reset_n) begin
        int cnt;
        logic lvl;
        if (!reset_n) begin
            m_active = 2'd0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_out    = 1'b0;
            m_en     = 1'b0;
        end else begin
            cnt    = int'(div_cnt);
            lvl    = div_level(m_active, cnt);
            m_en   = lvl && !m_out;
            m_out  = lvl;
            m_done = 1'b0;
            if (!m_busy) begin
                if (cfg_sel != m_active) m_busy = 1'b1;
            end else if (cfg_sel == m_active) begin
                m_busy = 1'b0;
            end else if (cnt == 7) begin
                m_active = cfg_sel;
                m_done   = 1'b1;
                m_busy   = 1'b0;
            end
        end
    end

    logic [5:0] dut_vec;
    logic [5:0] mdl_vec;
    assign dut_vec = {clk_out, clk_en, active_sel, sel_busy, switch_done};
    assign mdl_vec = {m_out, m_en, m_active, m_busy, m_done};

    // ---------------- driver tasks ----------------
    // Wait (at a negedge) until the divider shows count n.
    task automatic wait_count(input int n);
        for (int i = 0; i < 9; i++) begin
            if (int'(div_cnt) == n) return;
            @(negedge mclk);
        end
    endtask

    // Request a selection and let the model settle on it.
    task automatic settle(input logic [1:0] sel);
        cfg_sel = sel;
        for (int i = 0; i < 24; i++) begin
            @(negedge mclk);
            if (!m_busy && m_active == sel) return;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge mclk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({dut_vec, state_dbg} !== 7'd0) begin
            bad++;
            $display("FAIL reset_assert: got %b expected %b", {dut_vec, state_dbg}, 7'd0);
        end
        repeat (3) @(negedge mclk);
        reset_n = 1'b1;
        cfg_sel = 2'd0;
        for (int i = 0; i < 32; i++) begin
            @(negedge mclk);
            total++;
            if ({clk_out, clk_en, sel_busy} !== 3'b000 || dut_vec !== mdl_vec) begin
                bad++;
                $display("FAIL reset_idle cyc %0d: got %b expected %b", i, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_sel_div2();
        int dones;
        int ens;
        dones = 0;
        ens = 0;
        wait_count(2);
        cfg_sel = 2'd1;
        @(negedge mclk);
        total++;
        if (sel_busy !== 1'b1) begin
            bad++;
            $display("FAIL div2_busy: got %b expected 1", sel_busy);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge mclk);
            if (switch_done === 1'b1) dones++;
            total++;
            if (dut_vec !== mdl_vec) begin
                bad++;
                $display("FAIL div2_cycle %0d: got %b expected %b", i, dut_vec, mdl_vec);
            end
        end
        total++;
        if (dones != 1 || active_sel !== 2'd1) begin
            bad++;
            $display("FAIL div2_switch: got dones=%0d sel=%0d expected dones=1 sel=1", dones, active_sel);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge mclk);
            if (clk_en === 1'b1) ens++;
        end
        total++;
        if (ens != 4) begin
            bad++;
            $display("FAIL div2_en_rate: got %0d expected 4", ens);
        end
    endtask

    task automatic test_div2_to_div8();
        int highs;
        int ens;
        int seen;
        highs = 0;
        ens = 0;
        seen = 0;
        wait_count(4);
        cfg_sel = 2'd3;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge mclk);
            total++;
            if (dut_vec !== mdl_vec) begin
                bad++;
                $display("FAIL div8_cycle %0d: got %b expected %b", i, dut_vec, mdl_vec);
            end
            if (switch_done === 1'b1) seen = 1;
        end
        total++;
        if (seen != 1 || active_sel !== 2'd3) begin
            bad++;
            $display("FAIL div8_switch: got seen=%0d sel=%0d expected seen=1 sel=3", seen, active_sel);
        end
        // Two full div8 periods: low 4 then high 4, twice.
        for (int i = 0; i < 16; i++) begin
            @(negedge mclk);
            if (clk_out === 1'b1) highs++;
            if (clk_en === 1'b1) ens++;
            total++;
            if (clk_out !== ((i % 8) >= 4)) begin
                bad++;
                $display("FAIL div8_shape %0d: got %b expected %b", i, clk_out, ((i % 8) >= 4));
            end
        end
        total++;
        if (highs != 8 || ens != 2) begin
            bad++;
            $display("FAIL div8_rate: got highs=%0d ens=%0d expected 8 and 2", highs, ens);
        end
    endtask

    task automatic test_latest_wins();
        int dones;
        dones = 0;
        settle(2'd0);
        wait_count(1);
        cfg_sel = 2'd1;
        @(negedge mclk);
        cfg_sel = 2'd2;
        @(negedge mclk);
        cfg_sel = 2'd3;
        for (int i = 0; i < 12; i++) begin
            @(negedge mclk);
            if (switch_done === 1'b1) dones++;
            total++;
            if (dut_vec !== mdl_vec) begin
                bad++;
                $display("FAIL latest_cycle %0d: got %b expected %b", i, dut_vec, mdl_vec);
            end
        end
        total++;
        if (dones != 1 || active_sel !== 2'd3) begin
            bad++;
            $display("FAIL latest_wins: got dones=%0d sel=%0d expected dones=1 sel=3", dones, active_sel);
        end
    endtask

    task automatic test_cancel();
        int dones;
        int ens;
        dones = 0;
        ens = 0;
        settle(2'd1);
        wait_count(1);
        cfg_sel = 2'd2;
        wait_count(4);
        cfg_sel = 2'd1;
        for (int i = 0; i < 16; i++) begin
            @(negedge mclk);
            if (switch_done === 1'b1) dones++;
            if (clk_en === 1'b1) ens++;
            total++;
            if (dut_vec !== mdl_vec) begin
                bad++;
                $display("FAIL cancel_cycle %0d: got %b expected %b", i, dut_vec, mdl_vec);
            end
        end
        total++;
        if (dones != 0 || sel_busy !== 1'b0 || active_sel !== 2'd1 || ens != 8) begin
            bad++;
            $display("FAIL cancel: got dones=%0d busy=%b sel=%0d ens=%0d expected 0 0 1 8",
                     dones, sel_busy, active_sel, ens);
        end
    endtask

    task automatic test_random();
        logic [1:0] exp_q[$];
        logic [1:0] e;
        int         len;
        for (int n = 0; n < 60; n++) begin
            cfg_sel = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                @(negedge mclk);
                if (m_done) exp_q.push_back(m_active);
                total++;
                if (dut_vec !== mdl_vec) begin
                    bad++;
                    $display("FAIL random_cycle %0d.%0d: got %b expected %b", n, i, dut_vec, mdl_vec);
                end
                if (switch_done === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL random_switch: got switch to %0d expected none", active_sel);
                    end else begin
                        e = exp_q.pop_front();
                        if (active_sel !== e) begin
                            bad++;
                            $display("FAIL random_switch: got %0d expected %0d", active_sel, e);
                        end
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_missing: got %0d unmatched switches expected 0", exp_q.size());
        end
    endtask

    task automatic test_stuck_divider();
        settle(2'd0);
        hold = 1'b1;
        cfg_sel = 2'd2;
        @(negedge mclk);
        for (int i = 0; i < 100; i++) begin
            @(negedge mclk);
            total++;
            if (sel_busy !== 1'b1 || switch_done !== 1'b0 || dut_vec !== mdl_vec) begin
                bad++;
                $display("FAIL stuck_cycle %0d: got %b expected %b", i, dut_vec, mdl_vec);
            end
        end
        // Reset asserted between clock edges must take effect at once.
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({dut_vec, state_dbg} !== 7'd0) begin
            bad++;
            $display("FAIL stuck_async_reset: got %b expected %b", {dut_vec, state_dbg}, 7'd0);
        end
        @(negedge mclk);
        hold = 1'b0;
        cfg_sel = 2'd0;
        reset_n = 1'b1;
        repeat (4) @(negedge mclk);
        total++;
        if (dut_vec !== mdl_vec || active_sel !== 2'd0) begin
            bad++;
            $display("FAIL post_reset: got %b expected %b", dut_vec, mdl_vec);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sel_div2();
        test_div2_to_div8();
        test_latest_wins();
        test_cancel();
        test_random();
        test_stuck_divider();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
